// File: rtl/level_tick_pkg.sv
// Shared encodings and elaboration-time helpers for the level-driven game tick generator.
package level_tick_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned TICK_W  = 8;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_PERIODIC = 2'd1;
  localparam logic [STATE_W-1:0] ST_ONESHOT  = 2'd2;
  localparam logic [STATE_W-1:0] ST_PAUSED   = 2'd3;

  // Per-level period decrement; integer division leaves any remainder at the top level.
  function automatic int unsigned calc_step(input int unsigned base_period,
                                            input int unsigned min_period,
                                            input int unsigned levels);
    return (base_period - min_period) / (levels - 1);
  endfunction

  function automatic bit params_ok(input int unsigned base_period,
                                   input int unsigned min_period,
                                   input int unsigned levels,
                                   input int unsigned cnt_w);
    bit base_fits;
    base_fits = (cnt_w >= 33) || (64'(base_period) < (64'd1 << cnt_w));
    return (min_period >= 2) && (min_period < base_period) && (levels >= 2) && base_fits;
  endfunction

endpackage

// File: rtl/level_tick_gen_if.sv
// Control/status bundle between the game FSM, the tick generator and the row shifter.
interface level_tick_gen_if #(
  parameter int unsigned HEIGHT_W = 4,
  parameter int unsigned CNT_W    = 32
) ();

  logic [HEIGHT_W-1:0] height;
  logic                enable;
  logic                oneshot;
  logic                arm;
  logic                game_pulse;
  logic                blink;
  logic [7:0]          tick_cnt;
  logic [CNT_W-1:0]    period;
  logic                busy;

  modport master (
    output height, enable, oneshot, arm,
    input  game_pulse, blink, tick_cnt, period, busy
  );

  modport slave (
    input  height, enable, oneshot, arm,
    output game_pulse, blink, tick_cnt, period, busy
  );

endinterface

// File: rtl/level_tick_gen_period_calc.sv
// Maps the stack height to a pulse period: clamp to the top level, then BASE - STEP*level.
module level_period_calc
  import level_tick_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 100_000_000,
  parameter int unsigned MIN_PERIOD  = 5_000,
  parameter int unsigned LEVELS      = 11,
  parameter int unsigned HEIGHT_W    = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HEIGHT_W-1:0] height,
  output logic [CNT_W-1:0]    period
);

  localparam int unsigned STEP      = calc_step(BASE_PERIOD, MIN_PERIOD, LEVELS);
  localparam int unsigned TOP_LEVEL = LEVELS - 1;

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] target;

  always_comb begin
    if (32'(height) >= TOP_LEVEL) begin
      hc = CNT_W'(TOP_LEVEL);
    end else begin
      hc = CNT_W'(height);
    end
    target = CNT_W'(BASE_PERIOD) - (CNT_W'(STEP) * hc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period <= CNT_W'(BASE_PERIOD);
    end else begin
      period <= target;
    end
  end

endmodule

// File: rtl/level_tick_gen.sv
// Level-scaled game tick: periodic or one-shot pulse generator with pause, blink phase and pulse count.
module level_tick_gen
  import level_tick_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 100_000_000,
  parameter int unsigned MIN_PERIOD  = 5_000,
  parameter int unsigned LEVELS      = 11,
  parameter int unsigned HEIGHT_W    = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  level_tick_gen_if.slave  bus
);

  if (!params_ok(BASE_PERIOD, MIN_PERIOD, LEVELS, CNT_W)) begin : g_param_check
    $error("level_tick_gen: illegal BASE_PERIOD/MIN_PERIOD/LEVELS/CNT_W combination");
  end

  logic [STATE_W-1:0]  state, state_n;
  logic [STATE_W-1:0]  ret, ret_n;
  logic [CNT_W-1:0]    count, count_n;
  logic [HEIGHT_W-1:0] height_q;
  logic [CNT_W-1:0]    period_q;
  logic                hchg;
  logic                terminal;
  logic                pulse_n;
  logic                blink_n;
  logic [TICK_W-1:0]   tick_n;
  logic                busy_n;

  level_period_calc #(
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .LEVELS      (LEVELS),
    .HEIGHT_W    (HEIGHT_W),
    .CNT_W       (CNT_W)
  ) u_period (
    .clk    (clk),
    .rst    (rst),
    .height (bus.height),
    .period (period_q)
  );

  assign bus.period = period_q;

  // A height change restarts the interval; the new period lands on the same edge.
  assign hchg     = (bus.height != height_q);
  assign terminal = (count >= (period_q - CNT_W'(1)));

  always_comb begin
    state_n = state;
    ret_n   = ret;
    count_n = count;
    pulse_n = 1'b0;
    blink_n = bus.blink;
    tick_n  = bus.tick_cnt;

    case (state)
      ST_IDLE: begin
        count_n = '0;
        if (bus.enable && !bus.oneshot) begin
          state_n = ST_PERIODIC;
        end else if (bus.enable && bus.oneshot && bus.arm) begin
          state_n = ST_ONESHOT;
        end
      end

      ST_PERIODIC, ST_ONESHOT: begin
        if (hchg) begin
          count_n = '0;
        end else if ((state == ST_PERIODIC) && bus.oneshot) begin
          state_n = ST_IDLE;
          count_n = '0;
        end else if (!bus.enable) begin
          state_n = ST_PAUSED;
          ret_n   = state;
        end else if ((state == ST_ONESHOT) && bus.arm) begin
          count_n = '0;
        end else if (terminal) begin
          count_n = '0;
          pulse_n = 1'b1;
          blink_n = ~bus.blink;
          tick_n  = bus.tick_cnt + TICK_W'(1);
          if (state == ST_ONESHOT) begin
            state_n = ST_IDLE;
          end
        end else begin
          count_n = count + CNT_W'(1);
        end
      end

      ST_PAUSED: begin
        if (hchg) begin
          count_n = '0;
        end
        if (bus.enable) begin
          state_n = ret;
        end
      end

      default: begin
        state_n = ST_IDLE;
        count_n = '0;
      end
    endcase

    busy_n = (state_n == ST_PERIODIC) || (state_n == ST_ONESHOT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ret            <= ST_IDLE;
      count          <= '0;
      height_q       <= '0;
      bus.game_pulse <= 1'b0;
      bus.blink      <= 1'b0;
      bus.tick_cnt   <= '0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_n;
      ret            <= ret_n;
      count          <= count_n;
      height_q       <= bus.height;
      bus.game_pulse <= pulse_n;
      bus.blink      <= blink_n;
      bus.tick_cnt   <= tick_n;
      bus.busy       <= busy_n;
    end
  end

endmodule

// File: doc/level_tick_gen.md
Name: level_tick_gen

Overview:
- Parametrised successor to the game-speed clock divider.
- Turns `height` (stack level) into a single-cycle `game_pulse`. The pulse period shrinks linearly from BASE_PERIOD at height 0 to MIN_PERIOD at the top level.
- Adds pause, one-shot/retrigger mode, a blink phase output and a tick counter.
- Sits between the game FSM (height, enable, mode) and the row-shifting logic, which consumes `game_pulse`.

Parameters:
- BASE_PERIOD, 100_000_000, clk cycles between pulses at height 0.
- MIN_PERIOD, 5_000, clk cycles between pulses at height LEVELS-1 and above; must be >= 2 and < BASE_PERIOD.
- LEVELS, 11, number of distinct speed levels; must be >= 2.
- HEIGHT_W, 4, width of height.
- CNT_W, 32, counter width; 2**CNT_W must be > BASE_PERIOD.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- height  in  HEIGHT_W  current stack level.
- enable  in  1  0 = pause (count frozen), 1 = run.
- oneshot  in  1  mode select: 0 = periodic, 1 = one-shot.
- arm  in  1  one-shot start/retrigger strobe.
- game_pulse  out  1  registered, one clk wide.
- blink  out  1  toggles on every game_pulse.
- tick_cnt  out  8  number of pulses issued, wraps 255 -> 0.
- period  out  CNT_W  currently applied period.
- busy  out  1  high when the state is PERIODIC or ONESHOT.

Behaviour:
- STEP = (BASE_PERIOD - MIN_PERIOD)/(LEVELS-1), integer division. hc = min(height, LEVELS-1). Target period = BASE_PERIOD - STEP*hc, computed at CNT_W width.
- Registers updated every cycle: height_q <= height; period <= target(height).
- hchg = (height != height_q).
- Reset values: state IDLE, count 0, game_pulse 0, blink 0, tick_cnt 0, height_q 0, period = target(0) = BASE_PERIOD, ret 0.
- States: IDLE, PERIODIC, ONESHOT, PAUSED. `ret` holds the state to resume into.
- IDLE:
  - count = 0.
  - enable & !oneshot -> PERIODIC.
  - enable & oneshot & arm -> ONESHOT.
- PERIODIC and ONESHOT, one action per cycle in priority order:
  1. rst: reset everything.
  2. hchg: count <= 0, no pulse, state unchanged (speed change restarts the interval).
  3. PERIODIC only, oneshot=1: -> IDLE, count <= 0.
  4. !enable: -> PAUSED, ret <= current state, count held, no pulse.
  5. ONESHOT only, arm: count <= 0, no pulse (retrigger).
  6. count >= period-1: count <= 0, game_pulse <= 1, blink toggles, tick_cnt++. ONESHOT then -> IDLE.
  7. Otherwise: count++.
- Rule 6 uses `>=` as a safety net; in normal operation count never exceeds period-1, because every period change is preceded by an hchg reset.
- PAUSED:
  - count frozen.
  - enable -> ret state, no pulse on the resume cycle; counting continues from the frozen count on the next cycle.
  - hchg while paused clears count.
  - arm is ignored.
- Timing:
  - Consecutive periodic pulses are exactly `period` cycles apart.
  - First pulse is `period` cycles after the first cycle in PERIODIC or ONESHOT with count = 0.
  - Each cycle spent in PAUSED adds one cycle, and the resume cycle adds one more.
- game_pulse is low in every cycle not covered by rule 6.

Decomposition:
- Shared package level_tick_pkg:
  - state encoding localparams ST_IDLE=0, ST_PERIODIC=1, ST_ONESHOT=2, ST_PAUSED=3;
  - STEP derivation;
  - parameter-legality checks (MIN_PERIOD >= 2, LEVELS >= 2, BASE width).
- One sub-module, level_period_calc: height in, clamp, multiply-subtract, registered period out.
- level_tick_gen instantiates level_period_calc plus the FSM/counter.

Test Plan:
All scenarios use BASE_PERIOD=20, MIN_PERIOD=4, LEVELS=5, so STEP=4 and periods are 20/16/12/8/4.
- Reset, then enable=1, oneshot=0, height=0 held -> pulses exactly 20 cycles apart; blink toggles each pulse; tick_cnt counts 1, 2, 3; busy=1.
- Height steps 0 -> 2 mid-interval -> no pulse for the following 12 cycles, then pulses every 12. Height=9 -> period=4 (clamped), pulses every 4.
- Periodic at height=3 (period 8): drop enable for 5 cycles mid-count -> count frozen, busy=0; next pulse is delayed by 6 cycles versus the unpaused schedule. Drop enable on the terminal cycle -> no pulse until 2 cycles after resume.
- oneshot=1, arm pulse at height=1 -> exactly one game_pulse 16 cycles later, then IDLE with no further pulses. Re-arm at count 10 -> pulse 16 cycles after the re-arm, not 6.
- Run 256 pulses at height=4 -> tick_cnt wraps to 0. Assert rst mid-interval -> all outputs at reset values the next cycle, state IDLE, period=20.
